// File: rtl/mips_muldiv_unit.sv
// rtl/mips_muldiv_unit.sv - iterative MIPS multiply/divide unit with HI/LO registers
// Shift-add multiply and restoring divide on magnitudes, one bit per cycle, sign fix at the end.
module mips_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [WIDTH-1:0] LAST_ITER = WIDTH'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               accept;
  logic               a_sgn, b_sgn;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] prod_mag, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign accept = (state_q == S_IDLE) && start && !flush;

  // op[0]=0 selects the signed variants of MULT/DIV
  assign a_sgn = !op[0] && a[WIDTH-1];
  assign b_sgn = !op[0] && b[WIDTH-1];
  assign a_mag = a_sgn ? -a : a;
  assign b_mag = b_sgn ? -b : b;

  assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, m_q} : '0);
  assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, m_q};

  assign prod_mag = {acc_hi_q, acc_lo_q};
  assign prod_fix = neg_q ? -prod_mag : prod_mag;
  // Divide by zero yields an all-ones quotient; the remainder path already returns the dividend.
  assign quo_fix  = div0_q ? '1 : (neg_q ? -acc_lo_q : acc_lo_q);
  assign rem_fix  = rneg_q ? -acc_hi_q : acc_hi_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    m_d      = m_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    div0_d   = div0_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!op[2]) begin
            state_d  = S_RUN;
            cnt_d    = '0;
            is_div_d = op[1];
            m_d      = b_mag;
            acc_hi_d = '0;
            acc_lo_d = a_mag;
            neg_d    = a_sgn ^ b_sgn;
            rneg_d   = a_sgn;
            div0_d   = (b == '0);
          end else if (!op[1]) begin
            if (op[0]) lo_d = a;
            else       hi_d = a;
          end
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (is_div_q) begin
            acc_hi_d = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], !div_diff[WIDTH]};
          end else begin
            acc_hi_d = mul_sum[WIDTH:1];
            acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      m_q      <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      m_q      <= m_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      div0_q   <= div0_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// tb/tb_mips_muldiv_unit.sv - bench for mips_muldiv_unit (WIDTH=32 and WIDTH=8 instances)
module tb_mips_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  logic        start8, flush8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [7:0]  hi8, lo8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mips_muldiv_unit #(.WIDTH(32)) u_dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  mips_muldiv_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8), .flush(flush8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, ehi, elo;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV division truncates toward zero, % follows the dividend.
  function automatic logic [63:0] model(input logic [2:0] mop, input logic [31:0] ma, input logic [31:0] mb);
    longint      sa, sb, sq, sr;
    logic [63:0] ua, ub, r;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    ua = {32'b0, ma};
    ub = {32'b0, mb};
    r  = '0;
    case (mop)
      3'd0: r = sa * sb;
      3'd1: r = ua * ub;
      3'd2, 3'd3: begin
        if (mb == 0) r = {ma, 32'hFFFF_FFFF};
        else if (mop == 3'd2) begin
          sq = sa / sb;
          sr = sa % sb;
          r  = {sr[31:0], sq[31:0]};
        end else begin
          r = {ma % mb, ma / mb};
        end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Issues one mul/div, measures busy length, checks the done cycle and result.
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] xa,
                        input logic [31:0] xb, input logic [63:0] exp);
    int nb = 0;
    int guard = 0;
    @(negedge clk);
    start = 1'b1; op = o; a = xa; b = xb;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    while (!done && guard < 200) begin
      if (busy) nb++;
      @(negedge clk);
      guard++;
    end
    chk({name, "_done"}, {63'b0, done}, 64'd1);
    chk({name, "_busylen"}, 64'(nb), 64'd33);
    chk({name, "_busy_at_done"}, {63'b0, busy}, 64'd0);
    chk({name, "_hilo"}, {hi, lo}, exp);
  endtask

  initial begin
    logic [31:0] ra, rb, ph, pl;
    logic [2:0]  ro;
    int nb, guard, dseen;

    vecs[0] = '{3'd0, 32'hFFFF_FFFD, 32'd5,          32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[1] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{3'd3, 32'd7,         32'd0,          32'h0000_0007, 32'hFFFF_FFFF};
    vecs[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{3'd2, 32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[6] = '{3'd3, 32'd100,       32'd7,          32'd2,         32'd14};

    rst = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd7; a = '0; b = '0;
    start8 = 1'b0; flush8 = 1'b0; op8 = 3'd7; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    chk("reset_state", {30'b0, busy, done, hi, lo}, 64'd0);
    rst = 1'b1;

    for (int i = 0; i < 7; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].ehi, vecs[i].elo});

    for (int i = 0; i < 20; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = $urandom_range(0, 3);
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      run_op($sformatf("rnd%0d", i), ro, ra, rb, model(ro, ra, rb));
    end

    // MTHI then MTLO back to back
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'h1234;
    @(negedge clk);
    chk("mthi", {30'b0, busy, done, hi}, {32'b0, 32'h1234});
    op = 3'd5; a = 32'h5678;
    @(negedge clk);
    start = 1'b0;
    chk("mtlo", {30'b0, busy, done, hi, lo} , {30'b0, 2'b00, 32'h1234, 32'h5678});

    // no-op code leaves HI/LO alone
    start = 1'b1; op = 3'd6; a = 32'hAAAA;
    @(negedge clk);
    start = 1'b0;
    chk("noop", {30'b0, busy, done, hi, lo}, {30'b0, 2'b00, 32'h1234, 32'h5678});

    // MTHI while busy is ignored
    start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
    @(negedge clk);
    op = 3'd4; a = 32'hDEAD;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("mthi_busy", {hi, lo}, {32'h1234, 32'h5678});
    guard = 0;
    while (!done && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("divu_after_mthi", {hi, lo}, {32'd2, 32'd14});

    // flush mid-operation
    ph = hi; pl = lo;
    start = 1'b1; op = 3'd3; a = 32'd200; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", {63'b0, busy}, 64'd0);
    dseen = 0;
    repeat (40) begin
      if (done) dseen++;
      @(negedge clk);
    end
    chk("flush_no_done", 64'(dseen), 64'd0);
    chk("flush_hilo", {hi, lo}, {ph, pl});

    // flush with start in IDLE drops the request
    start = 1'b1; flush = 1'b1; op = 3'd4; a = 32'hBEEF;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_idle", {30'b0, busy, done, hi}, {32'b0, ph});

    // asynchronous reset mid-operation
    start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b0;
    #1 chk("rst_mid", {30'b0, busy, done, hi, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("rst_no_write", {30'b0, busy, done, hi, lo}, 64'd0);

    // WIDTH=8: MULT then a new start in the done cycle
    start8 = 1'b1; op8 = 3'd0; a8 = 8'h80; b8 = 8'h80;
    @(negedge clk);
    start8 = 1'b0;
    nb = 0; guard = 0;
    while (!done8 && guard < 50) begin
      if (busy8) nb++;
      @(negedge clk);
      guard++;
    end
    chk("w8_busylen", 64'(nb), 64'd9);
    chk("w8_mult", {47'b0, done8, hi8, lo8}, {47'b0, 1'b1, 16'h4000});
    start8 = 1'b1; op8 = 3'd1; a8 = 8'hFF; b8 = 8'hFF;
    @(negedge clk);
    start8 = 1'b0;
    chk("w8_back2back", {62'b0, busy8, done8}, 64'd2);
    nb = 0; guard = 0;
    while (!done8 && guard < 50) begin
      if (busy8) nb++;
      @(negedge clk);
      guard++;
    end
    chk("w8_busylen2", 64'(nb), 64'd9);
    chk("w8_multu", {47'b0, done8, hi8, lo8}, {47'b0, 1'b1, 16'hFE01});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
